frac_n_divider: RTL and testbench

FRAC_N_DIVIDER -- requirements
Module: frac_n_divider

---
 rtl/frac_n_divider.sv | 176 +++++++++++++++++
 tb/tb_frac_n_divider.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_n_divider.sv
// -----------------------------------------------------------------------------
// frac_n_divider
//
// Fractional-N feedback divider. Each output period lasts D cycles of clk,
// where D = int_div + mod_in (signed MASH sample), clamped to DIV_MIN. A new
// divisor is consumed on every mod_req edge: once when starting from idle
// (LOAD) and then at each terminal count while enable stays high, so
// consecutive periods follow each other without a gap.
//
// Parameters
//   WIDTH_INT  width of the unsigned integer ratio
//   ORDER      width of the signed modulator sample
//   DIV_MIN    smallest divisor that is ever applied
//
// Ports
//   clk         divider input clock (the only clock)
//   rst_n       asynchronous active-low reset
//   enable      run request
//   int_div     integer ratio N (unsigned)
//   mod_in      MASH output sample (signed two's complement)
//   mod_req     strobe: int_div/mod_in are consumed at the end of this cycle;
//               doubles as the modulator clock enable
//   div_pulse   strobe in the last cycle of every output period
//   div_out     divided clock, high for floor(D/2) cycles at period start
//   clamp_flag  sticky: some computed divisor was below DIV_MIN
//   mod_sum     (FRAC_DIV_ACCUM_EN only) wrap-around sum of consumed mod_in
//
// Optional feature: define FRAC_DIV_ACCUM_EN to add the mod_sum output.
// -----------------------------------------------------------------------------
module frac_n_divider #(
  parameter int WIDTH_INT = 8,
  parameter int ORDER     = 3,
  parameter int DIV_MIN   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic        [WIDTH_INT-1:0]          int_div,
  input  logic signed [ORDER-1:0]              mod_in,
  output logic                                 mod_req,
  output logic                                 div_pulse,
  output logic                                 div_out,
  output logic                                 clamp_flag
`ifdef FRAC_DIV_ACCUM_EN
  ,
  output logic signed [WIDTH_INT+ORDER-1:0]    mod_sum
`endif
);

  // Two guard bits above WIDTH_INT: one for the sign, one for the carry of
  // int_div + positive mod_in. The counter uses the same width so the clamped
  // divisor can be loaded without slicing.
  localparam int DW        = WIDTH_INT + 2;
  localparam int DIV_FLOOR = (DIV_MIN < 1) ? 1 : DIV_MIN;

  localparam logic signed [DW-1:0] DIV_MIN_S   = DW'(DIV_MIN);
  localparam logic signed [DW-1:0] DIV_FLOOR_S = DW'(DIV_FLOOR);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT
  } state_e;

  state_e               state_q, state_d;
  logic        [DW-1:0] cnt_q, cnt_d;
  logic        [DW-1:0] cur_div_q, cur_div_d;
  logic                 clamp_q, clamp_d;
  logic                 div_pulse_q, div_pulse_d;
  logic                 div_out_q, div_out_d;

  logic signed [DW-1:0] d_raw;
  logic signed [DW-1:0] d_eff;
  logic        [DW-1:0] div_new;

`ifdef FRAC_DIV_ACCUM_EN
  logic signed [WIDTH_INT+ORDER-1:0] sum_q, sum_d;
`endif

  // Divisor for the next period, evaluated every cycle but only used on a
  // mod_req edge.
  always_comb begin
    d_raw   = $signed(DW'(int_div)) + DW'(mod_in);
    // A DIV_MIN below 1 would let a zero divisor load cnt with -1, so the
    // substituted value never goes below 1 even though the flag follows DIV_MIN.
    d_eff   = (d_raw < DIV_FLOOR_S) ? DIV_FLOOR_S : d_raw;
    div_new = $unsigned(d_eff);
  end

  // mod_req depends on enable directly so a re-assertion in the terminal cycle
  // continues without a LOAD cycle.
  always_comb begin
    mod_req = (state_q == LOAD) ||
              ((state_q == COUNT) && (cnt_q == '0) && enable);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    clamp_d   = clamp_q;
`ifdef FRAC_DIV_ACCUM_EN
    sum_d     = sum_q;
`endif

    if (mod_req) begin
      state_d   = COUNT;
      cnt_d     = div_new - DW'(1);
      cur_div_d = div_new;
      if (d_raw < DIV_MIN_S) begin
        clamp_d = 1'b1;
      end
`ifdef FRAC_DIV_ACCUM_EN
      sum_d     = sum_q + (WIDTH_INT+ORDER)'(mod_in);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = LOAD;
          end
        end
        COUNT: begin
          // Terminal count without mod_req means enable is low: stop, cnt
          // stays at 0.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Outputs are registered by decoding the next state, which reproduces
    // the cycle-exact decode of (state, cnt, cur_div) without output glitches.
    div_pulse_d = (state_d == COUNT) && (cnt_d == '0);
    div_out_d   = (state_d == COUNT) &&
                  (cnt_d >= (cur_div_d - (cur_div_d >> 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_div_q   <= '0;
      clamp_q     <= 1'b0;
      div_pulse_q <= 1'b0;
      div_out_q   <= 1'b0;
`ifdef FRAC_DIV_ACCUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      clamp_q     <= clamp_d;
      div_pulse_q <= div_pulse_d;
      div_out_q   <= div_out_d;
`ifdef FRAC_DIV_ACCUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign div_pulse  = div_pulse_q;
  assign div_out    = div_out_q;
  assign clamp_flag = clamp_q;
`ifdef FRAC_DIV_ACCUM_EN
  assign mod_sum    = sum_q;
`endif

endmodule

// File: tb/tb_frac_n_divider.sv
// -----------------------------------------------------------------------------
// tb_frac_n_divider
//
// Bench for frac_n_divider. A period-position model (mode, position within
// the current period, period length) predicts mod_req, div_pulse, div_out,
// clamp_flag (and mod_sum when FRAC_DIV_ACCUM_EN is defined) every cycle.
// Directed sequences and a table of divisor patterns check latency, period
// length and duty against hand-derived constants; a random phase follows.
// -----------------------------------------------------------------------------
module tb_frac_n_divider;
  localparam int W    = 8;
  localparam int ORD  = 3;
  localparam int DMIN = 4;
  localparam int NTBL = 7;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic        [W-1:0]   int_div;
  logic signed [ORD-1:0] mod_in;
  logic                  mod_req;
  logic                  div_pulse;
  logic                  div_out;
  logic                  clamp_flag;
`ifdef FRAC_DIV_ACCUM_EN
  logic signed [W+ORD-1:0] mod_sum;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frac_n_divider #(
    .WIDTH_INT(W),
    .ORDER    (ORD),
    .DIV_MIN  (DMIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .int_div   (int_div),
    .mod_in    (mod_in),
    .mod_req   (mod_req),
    .div_pulse (div_pulse),
    .div_out   (div_out),
    .clamp_flag(clamp_flag)
`ifdef FRAC_DIV_ACCUM_EN
    ,
    .mod_sum   (mod_sum)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_RUN} mmode_e;
  mmode_e                m_mode;
  int                    m_pos;
  int                    m_len;
  logic                  m_clamp;
  logic signed [W+ORD-1:0] m_sum;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic obs_req, obs_pulse, obs_out;

  typedef struct {
    logic        [W-1:0]   id;
    logic signed [ORD-1:0] mi;
    int                    period;
    int                    high;
  } vec_t;
  vec_t tbl[NTBL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pos   = 0;
    m_len   = 1;
    m_clamp = 1'b0;
    m_sum   = '0;
  endtask

  task automatic check_outputs();
    logic e_req, e_pulse, e_out;
    e_pulse = (m_mode == M_RUN) && (m_pos == m_len - 1);
    e_req   = (m_mode == M_LOAD) || (e_pulse && enable);
    e_out   = (m_mode == M_RUN) && (m_pos < m_len / 2);
    chk("mod_req", 32'(mod_req), 32'(e_req));
    chk("div_pulse", 32'(div_pulse), 32'(e_pulse));
    chk("div_out", 32'(div_out), 32'(e_out));
    chk("clamp_flag", 32'(clamp_flag), 32'(m_clamp));
`ifdef FRAC_DIV_ACCUM_EN
    chk("mod_sum", 32'(mod_sum), 32'(m_sum));
`endif
    obs_req   = mod_req;
    obs_pulse = div_pulse;
    obs_out   = div_out;
  endtask

  task automatic model_advance(input logic en, input logic [W-1:0] id,
                               input logic signed [ORD-1:0] mi);
    logic req;
    int   d;
    req = (m_mode == M_LOAD) ||
          ((m_mode == M_RUN) && (m_pos == m_len - 1) && en);
    if (req) begin
      d = int'(id) + int'(mi);
      if (d < DMIN) begin
        d       = DMIN;
        m_clamp = 1'b1;
      end
      m_len  = d;
      m_pos  = 0;
      m_mode = M_RUN;
      m_sum  = m_sum + mi;
    end else if (m_mode == M_IDLE) begin
      if (en) m_mode = M_LOAD;
    end else if (m_mode == M_RUN) begin
      if (m_pos == m_len - 1) m_mode = M_IDLE;
      else m_pos++;
    end
  endtask

  // One clock cycle: drive inputs at edge+1, check at edge+2, advance model.
  task automatic cycle(input logic en, input logic [W-1:0] id,
                       input logic signed [ORD-1:0] mi);
    enable  = en;
    int_div = id;
    mod_in  = mi;
    #1;
    check_outputs();
    @(posedge clk);
    model_advance(en, id, mi);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mod_req", 32'(mod_req), 32'd0);
    chk("rst_div_pulse", 32'(div_pulse), 32'd0);
    chk("rst_div_out", 32'(div_out), 32'd0);
    chk("rst_clamp_flag", 32'(clamp_flag), 32'd0);
`ifdef FRAC_DIV_ACCUM_EN
    chk("rst_mod_sum", 32'(mod_sum), 32'd0);
`endif
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  // Start from idle with constant divisor; first pulse index counted in
  // cycles after the edge that samples enable.
  task automatic run_latency(input logic [W-1:0] id, input int exp_first,
                             input int exp_gap, input int exp_hi);
    int first, second, hi;
    first  = 0;
    second = 0;
    hi     = 0;
    cycle(1'b1, id, '0);
    for (int k = 1; k <= 80 && second == 0; k++) begin
      cycle(1'b1, id, '0);
      if (first != 0 && obs_out) hi++;
      if (obs_pulse) begin
        if (first == 0) first = k;
        else second = k;
      end
    end
    chk("first_pulse_latency", 32'(first), 32'(exp_first));
    chk("pulse_gap", 32'(second - first), 32'(exp_gap));
    chk("high_cycles", 32'(hi), 32'(exp_hi));
  endtask

  // Called right after a pulse with enable high: a D=10 period has just begun.
  task automatic run_drop();
    int   seen;
    logic req_at;
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'd10, '0);
    seen   = 0;
    req_at = 1'b1;
    for (int i = 1; i <= 30 && seen == 0; i++) begin
      cycle(1'b0, 8'd10, '0);
      if (obs_pulse) begin
        seen   = i;
        req_at = obs_req;
      end
    end
    chk("drop_cycles_to_pulse", 32'(seen), 32'd6);
    chk("drop_req_at_pulse", 32'(req_at), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'd10, '0);
      chk("drop_idle_div_out", 32'(obs_out), 32'd0);
      chk("drop_idle_pulse", 32'(obs_pulse), 32'd0);
    end
  endtask

  task automatic run_table();
    int idx, cur, cyc, hi, done, r;
    idx  = 0;
    cur  = -1;
    cyc  = 0;
    hi   = 0;
    done = 0;
    for (int k = 0; k < 400 && done < NTBL; k++) begin
      r = (idx < NTBL) ? idx : NTBL - 1;
      cycle(1'b1, tbl[r].id, tbl[r].mi);
      if (cur >= 0) begin
        cyc++;
        if (obs_out) hi++;
        if (obs_pulse) begin
          chk($sformatf("tbl%0d_period", cur), 32'(cyc), 32'(tbl[cur].period));
          chk($sformatf("tbl%0d_high", cur), 32'(hi), 32'(tbl[cur].high));
          done++;
          cur = -1;
        end
      end
      if (obs_req && idx < NTBL) begin
        cur = idx;
        idx++;
        cyc = 0;
        hi  = 0;
      end
    end
    chk("tbl_all_periods_seen", 32'(done), 32'(NTBL));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rv;
    int          np;

    tbl[0] = '{id: 8'd10, mi: 3'sd1,   period: 11, high: 5};
    tbl[1] = '{id: 8'd10, mi: 3'b111,  period: 9,  high: 4};  // -1
    tbl[2] = '{id: 8'd10, mi: 3'sd3,   period: 13, high: 6};
    tbl[3] = '{id: 8'd10, mi: 3'b100,  period: 6,  high: 3};  // -4
    tbl[4] = '{id: 8'd4,  mi: 3'b100,  period: 4,  high: 2};  // 4-4 -> clamp
    tbl[5] = '{id: 8'd5,  mi: 3'sd0,   period: 5,  high: 2};
    tbl[6] = '{id: 8'd20, mi: 3'b101,  period: 17, high: 8};  // -3

    rst_n   = 1'b1;
    enable  = 1'b0;
    int_div = '0;
    mod_in  = '0;
    model_reset();
    #2;
    do_reset();

    // Constant divisor 10: latency 11, period 10, 5 high.
    run_latency(8'd10, 11, 10, 5);
    run_drop();

    // Divisor sequences incl. clamp.
    run_table();
    for (int k = 0; k < 30; k++) cycle(1'b0, 8'd10, '0);
    chk("clamp_sticky_in_idle", 32'(clamp_flag), 32'd1);

    // Reset mid-period at cnt=3, then no pulse, then restart latency.
    run_latency(8'd10, 11, 10, 5);
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'd10, '0);
    do_reset();
    np = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 8'd10, '0);
      if (obs_pulse) np++;
    end
    chk("no_pulse_after_reset", 32'(np), 32'd0);
    run_latency(8'd10, 11, 10, 5);

`ifdef FRAC_DIV_ACCUM_EN
    do_reset();
    np = 0;
    for (int k = 0; k < 200 && np < 8; k++) begin
      cycle(1'b1, 8'd4, 3'sd1);
      if (obs_req) np++;
    end
    chk("mod_sum_after_8", 32'(mod_sum), 32'd8);
`endif

    // Random phase against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rv = $urandom;
      if (rv[31:24] < 8'd2) begin
        do_reset();
      end else begin
        cycle(rv[3:0] != 4'd0, {3'b000, rv[8:4]}, rv[11:9]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
